// File: rtl/sram_ctrl.sv
// Two-cycle read/write sequencer for a 256K x 16 asynchronous SRAM behind a one-cycle host strobe.
// Optional per-byte enables are built in when SRAM_CTRL_BYTE_MASK_EN is defined.
module sram_ctrl #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_f2s,
`ifdef SRAM_CTRL_BYTE_MASK_EN
    input  logic [1:0]        be,
`endif
    output logic              ready,
    output logic [DATA_W-1:0] data_s2f_r,
    output logic [DATA_W-1:0] data_s2f_ur,
    output logic [ADDR_W-1:0] ad,
    output logic              we_n,
    output logic              oe_n,
    inout  wire  [DATA_W-1:0] dio_a,
    output logic              ce_a_n,
    output logic              ub_a_n,
    output logic              lb_a_n
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        WR1  = 3'd3,
        WR2  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic              drv_q, drv_d;
    logic [DATA_W-1:0] rd_mask;

`ifdef SRAM_CTRL_BYTE_MASK_EN
    logic [1:0] be_q, be_d;
    logic       ub_n_q, ub_n_d;
    logic       lb_n_q, lb_n_d;

    assign rd_mask = {{(DATA_W-8){be_q[1]}}, {8{be_q[0]}}};
`else
    assign rd_mask = '1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        drv_d   = 1'b0;
`ifdef SRAM_CTRL_BYTE_MASK_EN
        be_d    = be_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mem) begin
                    addr_d = addr;
`ifdef SRAM_CTRL_BYTE_MASK_EN
                    be_d   = be;
`endif
                    if (rw) begin
                        state_d = RD1;
                    end else begin
                        wdata_d = data_f2s;
                        state_d = WR1;
                    end
                end
            end
            WR1: state_d = WR2;
            WR2: state_d = IDLE;
            RD1: state_d = RD2;
            RD2: begin
                state_d = IDLE;
                rdata_d = dio_a & rd_mask;
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so the registered pins line up with it.
        unique case (state_d)
            WR1: begin
                we_n_d = 1'b0;
                drv_d  = 1'b1;
            end
            WR2:     drv_d  = 1'b1;
            RD1,
            RD2:     oe_n_d = 1'b0;
            default: ;
        endcase
    end

`ifdef SRAM_CTRL_BYTE_MASK_EN
    always_comb begin
        ub_n_d = 1'b1;
        lb_n_d = 1'b1;
        if (state_d != IDLE) begin
            ub_n_d = ~be_d[1];
            lb_n_d = ~be_d[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            be_q   <= '0;
            ub_n_q <= 1'b1;
            lb_n_q <= 1'b1;
        end else begin
            be_q   <= be_d;
            ub_n_q <= ub_n_d;
            lb_n_q <= lb_n_d;
        end
    end

    assign ub_a_n = ub_n_q;
    assign lb_a_n = lb_n_q;
`else
    assign ub_a_n = 1'b0;
    assign lb_a_n = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            drv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            drv_q   <= drv_d;
        end
    end

    // Bus stays driven through WR2 to cover data hold after we_n rises.
    assign dio_a       = drv_q ? wdata_q : {DATA_W{1'bz}};
    assign data_s2f_ur = dio_a;
    assign data_s2f_r  = rdata_q;
    assign ready       = (state_q == IDLE);
    assign ad          = addr_q;
    assign we_n        = we_n_q;
    assign oe_n        = oe_n_q;
    assign ce_a_n      = 1'b0;

endmodule

// File: tb/tb_sram_ctrl.sv
// Random + directed bench for sram_ctrl: driver feeds a scoreboard queue from a memory
// reference model; a negedge monitor pops and checks each bus sequence it observes.
module tb_sram_ctrl;
    logic        clk;
    logic        reset;
    logic        mem;
    logic        rw;
    logic [17:0] addr;
    logic [15:0] data_f2s;
    logic        ready;
    logic [15:0] data_s2f_r;
    logic [15:0] data_s2f_ur;
    logic [17:0] ad;
    logic        we_n;
    logic        oe_n;
    wire  [15:0] dio_a;
    logic        ce_a_n;
    logic        ub_a_n;
    logic        lb_a_n;

    sram_ctrl dut (
        .clk(clk), .reset(reset), .mem(mem), .rw(rw), .addr(addr), .data_f2s(data_f2s),
        .ready(ready), .data_s2f_r(data_s2f_r), .data_s2f_ur(data_s2f_ur), .ad(ad),
        .we_n(we_n), .oe_n(oe_n), .dio_a(dio_a), .ce_a_n(ce_a_n), .ub_a_n(ub_a_n), .lb_a_n(lb_a_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External SRAM device model
    logic [15:0] sram [0:262143];
    assign dio_a = (!oe_n && !ce_a_n) ? sram[ad] : 16'bz;
    initial begin
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset && !we_n && !ce_a_n) sram[ad] = dio_a;
        end
    end

    typedef struct {
        bit          rd;
        logic [17:0] a;
        logic [15:0] d;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_mem [int];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_acc = 0;
    bit          acc_vld = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_rd(input logic [17:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 16'h0000;
    endfunction

    // One host cycle; acceptance is decided from the model's own notion of ready.
    task automatic drive(input bit m, input bit r, input logic [17:0] a, input logic [15:0] d,
                         output bit acc);
        bit   exp_rdy;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        exp_rdy = !acc_vld || (cyc - last_acc >= 3);
        chk("ready", 32'(ready), 32'(exp_rdy));
        mem = m; rw = r; addr = a; data_f2s = d;
        acc = exp_rdy && m;
        if (acc) begin
            e.rd = r;
            e.a  = a;
            if (r) e.d = ref_rd(a);
            else begin
                ref_mem[int'(a)] = d;
                e.d = d;
            end
            q.push_back(e);
            last_acc = cyc;
            acc_vld  = 1'b1;
        end
    endtask

    task automatic req(input bit r, input logic [17:0] a, input logic [15:0] d);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 10) begin
            drive(1'b1, r, a, d, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: request to %0h never accepted", a);
        end
    endtask

    // Monitor: decoupled from the driver, reacts to what the bus does.
    initial begin
        int          oe_cnt;
        bit          wr_hold;
        logic [15:0] hold_d;
        exp_t        e;
        oe_cnt  = 0;
        wr_hold = 1'b0;
        hold_d  = 16'h0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                oe_cnt  = 0;
                wr_hold = 1'b0;
            end else begin
                if (!we_n) begin
                    chk("we_oe_excl", 32'(oe_n), 32'd1);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL wr_unexpected: write strobe at ad=%0h with nothing outstanding", ad);
                    end else begin
                        e = q.pop_front();
                        chk("wr_kind", 32'(e.rd), 32'd0);
                        chk("wr_addr", 32'(ad), 32'(e.a));
                        chk("wr_bus", 32'(dio_a), 32'(e.d));
                        chk("wr1_ready", 32'(ready), 32'd0);
                        hold_d  = e.d;
                        wr_hold = 1'b1;
                    end
                end else if (wr_hold) begin
                    chk("wr_hold_bus", 32'(dio_a), 32'(hold_d));
                    chk("wr2_ready", 32'(ready), 32'd0);
                    wr_hold = 1'b0;
                end
                if (!oe_n) begin
                    oe_cnt++;
                    chk("rd_ready", 32'(ready), 32'd0);
                    if (q.size() > 0) chk("rd_ur", 32'(data_s2f_ur), 32'(q[0].d));
                end else if (oe_cnt != 0) begin
                    chk("rd_oe_len", 32'(oe_cnt), 32'd2);
                    oe_cnt = 0;
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_unexpected: read cycle at ad=%0h with nothing outstanding", ad);
                    end else begin
                        e = q.pop_front();
                        chk("rd_kind", 32'(e.rd), 32'd1);
                        chk("rd_addr", 32'(ad), 32'(e.a));
                        chk("rd_data", 32'(data_s2f_r), 32'(e.d));
                        chk("rd_done_ready", 32'(ready), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        bit          acc;
        bit          had;
        logic [15:0] old;
        logic [17:0] a;
        reset = 1'b0; mem = 1'b0; rw = 1'b0; addr = '0; data_f2s = '0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_we_n", 32'(we_n), 32'd1);
        chk("rst_oe_n", 32'(oe_n), 32'd1);
        chk("rst_rdata", 32'(data_s2f_r), 32'd0);
        chk("rst_ad", 32'(ad), 32'd0);
        chk("ce_a_n", 32'(ce_a_n), 32'd0);
        chk("ub_lb", 32'({ub_a_n, lb_a_n}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Directed accesses
        req(1'b0, 18'h000F0, 16'h00F0);
        req(1'b1, 18'h000F0, 16'h0000);
        req(1'b0, 18'h000FF, 16'h00FF);
        req(1'b1, 18'h000F0, 16'h0000);
        req(1'b1, 18'h000FF, 16'h0000);
        req(1'b0, 18'h3FFFF, 16'hA5C3);
        req(1'b1, 18'h3FFFF, 16'h0000);

        // Busy rejection: mem held high, address/data changing every cycle
        for (int i = 0; i < 12; i++)
            drive(1'b1, 1'b0, 18'(20 + i), 16'(16'h1000 + i), acc);
        for (int i = 0; i < 12; i++)
            req(1'b1, 18'(20 + i), 16'h0000);

        // Reset in the middle of a write
        a   = 18'h00123;
        had = ref_mem.exists(int'(a));
        old = ref_rd(a);
        req(1'b0, a, 16'hBEEF);
        drive(1'b0, 1'b0, '0, '0, acc);
        chk("wr1_we_low", 32'(we_n), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("midrst_we_n", 32'(we_n), 32'd1);
        chk("midrst_oe_n", 32'(oe_n), 32'd1);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_ad", 32'(ad), 32'd0);
        if (had) ref_mem[int'(a)] = old;
        else ref_mem.delete(int'(a));
        q.delete();
        acc_vld = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        req(1'b1, a, 16'h0000);

        // Random traffic over a small address window at both ends of the space
        for (int i = 0; i < 400; i++) begin
            logic [17:0] ra;
            ra = 18'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) ra = ra | 18'h3FFF0;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra, 16'($urandom), acc);
        end

        for (int i = 0; i < 10 && q.size() != 0; i++)
            drive(1'b0, 1'b0, '0, '0, acc);
        repeat (2) @(posedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Single-port asynchronous SRAM controller with a simple host request interface.
- Converts one-cycle mem/rw requests into two-cycle SRAM read or write bus sequences on an 18-bit address / 16-bit bidirectional data bus.
- Sits between FPGA user logic and an external 256K x 16 SRAM chip (chip "a").

Parameters:
- ADDR_W, 18, address width of host and SRAM address bus.
- DATA_W, 16, data width of host and SRAM data bus.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem  input  1  request strobe; sampled only while ready=1.
- rw  input  1  request type: 1=read, 0=write.
- addr  input  ADDR_W  request address.
- data_f2s  input  DATA_W  write data, host to SRAM.
- ready  output  1  controller idle; accepts a request this cycle.
- data_s2f_r  output  DATA_W  registered read data, valid from the cycle ready returns after a read.
- data_s2f_ur  output  DATA_W  unregistered read data, a continuous copy of dio_a.
- ad  output  ADDR_W  SRAM address.
- we_n  output  1  SRAM write enable, active low.
- oe_n  output  1  SRAM output enable, active low.
- dio_a  inout  DATA_W  SRAM data bus.
- ce_a_n  output  1  chip enable, active low.
- ub_a_n  output  1  upper byte enable, active low.
- lb_a_n  output  1  lower byte enable, active low.

Behaviour:
- FSM states: IDLE, RD1, RD2, WR1, WR2.
- Reset (reset=0, asynchronous): state=IDLE, addr_reg=0, wdata_reg=0, rdata_reg=0, we_n=1, oe_n=1, dio_a released to Z.
- IDLE:
  - ready=1.
  - If mem=1: latch addr into addr_reg.
  - rw=0: also latch data_f2s into wdata_reg; next state WR1.
  - rw=1: next state RD1.
  - If mem=0: stay in IDLE.
- WR1 -> WR2 -> IDLE; ready=0 throughout.
  - we_n=0 in WR1 only.
  - wdata_reg drives dio_a in WR1 and WR2. The bus is held one extra cycle after the we_n rising edge for hold time.
- RD1 -> RD2 -> IDLE; ready=0 throughout.
  - oe_n=0 in RD1 and RD2.
  - On the clock edge leaving RD2, rdata_reg <= dio_a.
- we_n, oe_n and the tri-state enable are registered outputs (computed from next state), so they are glitch-free and aligned with state.
- ad = addr_reg at all times.
- The address is stable for the whole access. Requests presented while ready=0 are ignored, not queued.
- Latency:
  - write occupies 2 cycles after acceptance;
  - read data is on data_s2f_r 2 cycles after acceptance (same cycle ready=1);
  - back-to-back requests: one accepted every 3 cycles.
- ce_a_n=0 constant. ub_a_n=lb_a_n=0 unless the optional feature is enabled.
- dio_a is Z whenever the controller is not in WR1/WR2. The controller never drives the bus while oe_n=0.
- data_s2f_r holds its value until the next completed read.
- Reset asserted mid-access: the sequence aborts immediately, the bus is released, and we_n/oe_n are deasserted.

Optional Feature:
- Macro SRAM_CTRL_BYTE_MASK_EN.
- When defined:
  - adds input be[1:0] (active-high byte enables), latched with addr on request acceptance;
  - ub_a_n = ~be_reg[1], lb_a_n = ~be_reg[0] during RD1/RD2/WR1/WR2, and both are 1 in IDLE;
  - for reads, disabled bytes of data_s2f_r are zeroed.
- When undefined: no be port; ub_a_n=lb_a_n=0 constant; full 16-bit accesses.

Test Plan:
- Reset: hold reset=0 for 5 cycles -> ready=1, we_n=1, oe_n=1, dio_a=Z, data_s2f_r=0, ad=0.
- Write: mem=1, rw=0, addr=0x000F0, data_f2s=0x00F0 for one cycle -> ad=0x000F0, we_n low for exactly 1 cycle, dio_a=0x00F0 for 2 cycles, ready low for 2 cycles.
- Read-back: mem=1, rw=1, addr=0x000F0 -> oe_n low 2 cycles; data_s2f_r=0x00F0 when ready returns; dio_a never driven by the controller.
- Second location: write 0x00FF to 0x000FF, read 0x000F0 then 0x000FF -> 0x00F0, then 0x00FF; data_s2f_ur follows the SRAM bus during RD1/RD2.
- Busy rejection: hold mem=1, rw=0, and change addr/data_f2s every cycle -> only values present in IDLE cycles are written; a new request is accepted every 3 cycles.
- Mid-access reset: assert reset during WR1 -> immediately we_n=1, dio_a=Z, state IDLE after release; a subsequent read proceeds normally.
